// File: rtl/vga_pkg.sv
// Shared VGA timing constants, picture-window defaults and arbiter state encoding.
package vga_pkg;

    // 640x480 @ 60 Hz horizontal timing (pixels)
    localparam int unsigned HA = 640;
    localparam int unsigned HF = 16;
    localparam int unsigned HS = 96;
    localparam int unsigned HB = 48;
    localparam int unsigned HT = HA + HF + HS + HB;

    // 640x480 @ 60 Hz vertical timing (lines)
    localparam int unsigned VA = 480;
    localparam int unsigned VF = 10;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 33;
    localparam int unsigned VT = VA + VF + VS + VB;

    // Default picture window held in the frame buffer
    localparam int unsigned PIC_H_DFLT = 280;
    localparam int unsigned PIC_V_DFLT = 210;
    localparam int unsigned PIX_TOTAL  = PIC_H_DFLT * PIC_V_DFLT;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_FRAME  = 2'd1,
        S_VBLANK = 2'd2
    } fb_state_t;

endpackage

// File: rtl/vga_fb_rd_ptr.sv
// Display read pointer: walks the frame buffer one pixel per issued read and
// counts reads so the arbiter knows when the last pixel of the frame went out.
module vga_fb_rd_ptr #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PIX_N  = 58800
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              load_zero,
    input  logic              inc,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              last_pix
);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(PIX_N - 1);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(PIX_N - 1);

    logic [ADDR_W:0] pix_cnt;

    // Restart takes precedence; a read in the restart cycle used address 0,
    // so the pointer and count land on 1 rather than 0.
    always_ff @(posedge clk25) begin
        if (rst) begin
            rd_ptr  <= '0;
            pix_cnt <= '0;
        end else if (load_zero) begin
            rd_ptr  <= inc ? ADDR_W'(1) : '0;
            pix_cnt <= inc ? (ADDR_W + 1)'(1) : '0;
        end else if (inc) begin
            rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // The read being issued now is the final pixel of the frame
    always_comb begin
        last_pix = (pix_cnt == LAST_CNT);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: the display fetch owns the RAM port inside the
// picture window; host writes use every cycle the display leaves free.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned PIC_H          = PIC_H_DFLT,
    parameter int unsigned PIC_V          = PIC_V_DFLT,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 24,
    parameter int unsigned WR_VBLANK_ONLY = 0
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pic_active,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              err_overrun,
    output logic              err_short,
    output logic              err_range
);
    localparam logic [ADDR_W:0] PIX_N = (ADDR_W + 1)'(PIC_H * PIC_V);

    fb_state_t         state;
    logic [ADDR_W-1:0] rd_ptr;
    logic              last_pix;
    logic              rd_issue;
    logic              wr_xfer;
    logic              in_range;

    // Port arbitration: a display read excludes any write because wr_ready
    // is low whenever pic_active is high.
    always_comb begin
        rd_issue  = pic_active && (frame_start || (state == S_FRAME));
        wr_ready  = !rst && !pic_active && ((state != S_FRAME) || (WR_VBLANK_ONLY == 0));
        wr_xfer   = wr_valid && wr_ready;
        in_range  = ({1'b0, wr_addr} < PIX_N);
        mem_addr  = rd_ptr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rd_issue) begin
            if (frame_start) begin
                mem_addr = '0;
            end
        end else if (wr_xfer) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_we    = in_range;
        end
        pix_data = pix_valid ? mem_rdata : '0;
    end

    vga_fb_rd_ptr #(
        .ADDR_W (ADDR_W),
        .PIX_N  (PIC_H * PIC_V)
    ) u_rd_ptr (
        .clk25     (clk25),
        .rst       (rst),
        .load_zero (frame_start),
        .inc       (rd_issue),
        .rd_ptr    (rd_ptr),
        .last_pix  (last_pix)
    );

    // Frame sequencing, pixel-valid pipeline and sticky error flags
    always_ff @(posedge clk25) begin
        if (rst) begin
            state       <= S_WAIT;
            pix_valid   <= 1'b0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            pix_valid <= rd_issue;
            if (frame_start) begin
                if (state == S_FRAME) begin
                    err_short <= 1'b1;
                end
                state <= S_FRAME;
            end else begin
                case (state)
                    S_FRAME: begin
                        if (rd_issue && last_pix) begin
                            state <= S_VBLANK;
                        end
                    end
                    S_WAIT, S_VBLANK: begin
                        if (pic_active) begin
                            err_overrun <= 1'b1;
                        end
                    end
                    default: state <= S_WAIT;
                endcase
            end
            if (wr_xfer && !in_range) begin
                err_range <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter: full-frame fetch, horizontal-gap
// writes, vblank-only writes, short frame, range/overrun errors, mid-line reset.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 24;
    localparam int unsigned H_GAP = (HT - HA) / 20;   // 8-cycle scaled line gap
    localparam int unsigned V_GAP = VT - VA;          // 45 idle cycles after a frame
    localparam int unsigned AWB   = 4;
    localparam int unsigned PHB   = 4;
    localparam int unsigned PVB   = 3;
    localparam int unsigned GAPB  = 3;

    logic clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    // DUT A: default geometry, writes allowed in horizontal gaps
    logic          rst = 1'b1, frame_start = 1'b0, pic_active = 1'b0, wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, mem_we, pix_valid, err_overrun, err_short, err_range;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, pix_data;

    // DUT B: tiny picture, writes only outside S_FRAME
    logic           rst_b = 1'b1, frame_start_b = 1'b0, pic_active_b = 1'b0, wr_valid_b = 1'b0;
    logic [AWB-1:0] wr_addr_b = '0;
    logic [DW-1:0]  wr_data_b = '0;
    logic [DW-1:0]  mem_rdata_b = '0;
    logic           wr_ready_b, mem_we_b, pix_valid_b, err_overrun_b, err_short_b, err_range_b;
    logic [AWB-1:0] mem_addr_b;
    logic [DW-1:0]  mem_wdata_b, pix_data_b;

    int n_vec = 0;
    int n_bad = 0;

    vga_fb_arbiter dut (
        .clk25(clk25), .rst(rst), .frame_start(frame_start), .pic_active(pic_active),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .err_overrun(err_overrun),
        .err_short(err_short), .err_range(err_range)
    );

    vga_fb_arbiter #(.PIC_H(PHB), .PIC_V(PVB), .ADDR_W(AWB), .DATA_W(DW), .WR_VBLANK_ONLY(1)) dut_b (
        .clk25(clk25), .rst(rst_b), .frame_start(frame_start_b), .pic_active(pic_active_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .pix_data(pix_data_b), .pix_valid(pix_valid_b), .err_overrun(err_overrun_b),
        .err_short(err_short_b), .err_range(err_range_b)
    );

    // RAM behind DUT A: unwritten locations read back their own address
    bit [DW-1:0] ram_val [1 << AW];
    bit          ram_wr  [1 << AW];
    always @(posedge clk25) begin
        if (mem_we) begin
            ram_val[mem_addr] <= mem_wdata;
            ram_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr] ? ram_val[mem_addr] : DW'(mem_addr);
    end

    // Bench-side expectation of RAM contents
    bit [DW-1:0] exp_val [1 << AW];
    bit          exp_wr  [1 << AW];
    bit          prev_rd;
    int          prev_idx;

    function automatic logic [DW-1:0] exp_pix(int idx);
        return exp_wr[idx] ? exp_val[idx] : DW'(idx);
    endfunction

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; frame_start = 1'b0; pic_active = 1'b0; wr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        prev_rd = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1; pic_active = 1'b1; wr_valid = 1'b1; wr_addr = AW'(5);
        #2;
        n_vec++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL reset_comb: wr_ready=%b mem_we=%b required 0 0", wr_ready, mem_we);
        tick();
        pic_active = 1'b0; wr_valid = 1'b0;
        #2;
        n_vec++;
        if (pix_valid !== 1'b0 || pix_data !== '0 || err_overrun !== 1'b0 || err_short !== 1'b0 || err_range !== 1'b0)
            $display("FAIL reset_regs: pv=%b pd=%h eo=%b es=%b er=%b required all 0",
                     pix_valid, pix_data, err_overrun, err_short, err_range);
        n_vec++;
        if (dut.state !== S_WAIT || mem_addr !== '0)
            $display("FAIL reset_state: state=%0d mem_addr=%h required %0d 0", dut.state, mem_addr, S_WAIT);
        tick();
        rst = 1'b0;
        prev_rd = 1'b0;
    endtask

    task automatic test_full_frame();
        int idx = 0;
        do_reset();
        for (int v = 0; v < int'(PIC_V_DFLT); v++) begin
            for (int h = 0; h < int'(PIC_H_DFLT + H_GAP); h++) begin
                tick();
                frame_start = (v == 0 && h == 0);
                pic_active  = (h < int'(PIC_H_DFLT));
                #2;
                n_vec++;
                if (pix_valid !== prev_rd || pix_data !== (prev_rd ? exp_pix(prev_idx) : DW'(0))) begin
                    n_bad++;
                    $display("FAIL frame_pix: idx=%0d pv=%b pd=%h required %b %h", prev_idx, pix_valid,
                             pix_data, prev_rd, prev_rd ? exp_pix(prev_idx) : DW'(0));
                end
                if (pic_active) begin
                    n_vec++;
                    if (mem_addr !== AW'(idx) || mem_we !== 1'b0) begin
                        n_bad++;
                        $display("FAIL frame_addr: addr=%h we=%b required %h 0", mem_addr, mem_we, AW'(idx));
                    end
                    prev_rd = 1'b1; prev_idx = idx; idx++;
                end else begin
                    prev_rd = 1'b0;
                end
                if (v == int'(PIC_V_DFLT) - 1 && h == int'(PIC_H_DFLT) - 1) begin
                    n_vec++;
                    if (dut.state !== S_FRAME) begin
                        n_bad++;
                        $display("FAIL frame_state_last: state=%0d required %0d", dut.state, S_FRAME);
                    end
                end
                if (v == int'(PIC_V_DFLT) - 1 && h == int'(PIC_H_DFLT)) begin
                    n_vec++;
                    if (dut.state !== S_VBLANK) begin
                        n_bad++;
                        $display("FAIL frame_state_vblank: state=%0d required %0d", dut.state, S_VBLANK);
                    end
                end
            end
        end
        for (int i = 0; i < int'(V_GAP); i++) tick();
        #2;
        n_vec++;
        if (dut.state !== S_VBLANK || pix_valid !== 1'b0 || pix_data !== '0) begin
            n_bad++;
            $display("FAIL frame_idle: state=%0d pv=%b pd=%h required %0d 0 0", dut.state, pix_valid, pix_data, S_VBLANK);
        end
        n_vec++;
        if (err_overrun !== 1'b0 || err_short !== 1'b0 || err_range !== 1'b0 || idx != int'(PIX_TOTAL)) begin
            n_bad++;
            $display("FAIL frame_errs: eo=%b es=%b er=%b reads=%0d required 0 0 0 %0d",
                     err_overrun, err_short, err_range, idx, PIX_TOTAL);
        end
    endtask

    task automatic test_hgap_writes();
        int k = 0;
        int idx = 0;
        do_reset();
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < int'(PIC_H_DFLT + H_GAP); h++) begin
                tick();
                frame_start = (v == 0 && h == 0);
                pic_active  = (h < int'(PIC_H_DFLT));
                wr_valid    = (v == 0);
                wr_addr     = AW'(PIC_H_DFLT + k);
                wr_data     = 24'hC0_0000 + DW'(k);
                #2;
                n_vec++;
                if (pix_valid !== prev_rd || pix_data !== (prev_rd ? exp_pix(prev_idx) : DW'(0))) begin
                    n_bad++;
                    $display("FAIL hgap_pix: idx=%0d pv=%b pd=%h required %b %h", prev_idx, pix_valid,
                             pix_data, prev_rd, prev_rd ? exp_pix(prev_idx) : DW'(0));
                end
                n_vec++;
                if (wr_ready !== (wr_valid | !wr_valid) & !pic_active || mem_we !== (wr_valid && !pic_active)) begin
                    n_bad++;
                    $display("FAIL hgap_ready: pa=%b wr_ready=%b mem_we=%b required %b %b", pic_active,
                             wr_ready, mem_we, !pic_active, wr_valid && !pic_active);
                end
                if (pic_active) begin
                    n_vec++;
                    if (mem_addr !== AW'(idx)) begin
                        n_bad++;
                        $display("FAIL hgap_raddr: addr=%h required %h", mem_addr, AW'(idx));
                    end
                    prev_rd = 1'b1; prev_idx = idx; idx++;
                end else begin
                    prev_rd = 1'b0;
                    if (wr_valid) begin
                        n_vec++;
                        if (mem_addr !== wr_addr || mem_wdata !== wr_data) begin
                            n_bad++;
                            $display("FAIL hgap_wr: addr=%h data=%h required %h %h", mem_addr, mem_wdata, wr_addr, wr_data);
                        end
                        exp_wr[PIC_H_DFLT + k]  = 1'b1;
                        exp_val[PIC_H_DFLT + k] = wr_data;
                        k++;
                    end
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_short_frame();
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            tick();
            frame_start = (i == 0);
            pic_active  = 1'b1;
        end
        tick();
        frame_start = 1'b1; pic_active = 1'b0;
        #2;
        n_vec++;
        if (err_short !== 1'b0 || pix_valid !== 1'b1 || pix_data !== exp_pix(999)) begin
            n_bad++;
            $display("FAIL short_before: es=%b pv=%b pd=%h required 0 1 %h", err_short, pix_valid, pix_data, exp_pix(999));
        end
        tick();
        frame_start = 1'b0; pic_active = 1'b1;
        #2;
        n_vec++;
        if (err_short !== 1'b1 || dut.u_rd_ptr.pix_cnt !== '0 || mem_addr !== '0 || pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL short_restart: es=%b cnt=%0d addr=%h pv=%b required 1 0 0 0",
                     err_short, dut.u_rd_ptr.pix_cnt, mem_addr, pix_valid);
        end
        tick();
        pic_active = 1'b0;
        #2;
        n_vec++;
        if (pix_valid !== 1'b1 || pix_data !== exp_pix(0) || dut.u_rd_ptr.pix_cnt !== 17'd1 || dut.state !== S_FRAME) begin
            n_bad++;
            $display("FAIL short_next: pv=%b pd=%h cnt=%0d state=%0d required 1 %h 1 %0d",
                     pix_valid, pix_data, dut.u_rd_ptr.pix_cnt, dut.state, exp_pix(0), S_FRAME);
        end
    endtask

    task automatic test_range_overrun();
        do_reset();
        tick();
        wr_valid = 1'b1; wr_addr = AW'(PIX_TOTAL - 1); wr_data = 24'h12_3456;
        #2;
        n_vec++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(PIX_TOTAL - 1)) begin
            n_bad++;
            $display("FAIL range_last_ok: rdy=%b we=%b addr=%h required 1 1 %h", wr_ready, mem_we, mem_addr, AW'(PIX_TOTAL - 1));
        end
        exp_wr[PIX_TOTAL - 1] = 1'b1; exp_val[PIX_TOTAL - 1] = 24'h12_3456;
        tick();
        wr_addr = AW'(PIX_TOTAL); wr_data = 24'h65_4321;
        #2;
        n_vec++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b0 || err_range !== 1'b0) begin
            n_bad++;
            $display("FAIL range_oob: rdy=%b we=%b er=%b required 1 0 0", wr_ready, mem_we, err_range);
        end
        tick();
        wr_valid = 1'b0;
        #2;
        n_vec++;
        if (err_range !== 1'b1 || err_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL range_flag: er=%b eo=%b required 1 0", err_range, err_overrun);
        end
        tick();
        pic_active = 1'b1;
        #2;
        n_vec++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_port: rdy=%b we=%b required 0 0", wr_ready, mem_we);
        end
        tick();
        pic_active = 1'b0;
        #2;
        n_vec++;
        if (err_overrun !== 1'b1 || pix_valid !== 1'b0 || pix_data !== '0 || err_short !== 1'b0 || dut.state !== S_WAIT) begin
            n_bad++;
            $display("FAIL overrun_flag: eo=%b pv=%b pd=%h es=%b state=%0d required 1 0 0 0 %0d",
                     err_overrun, pix_valid, pix_data, err_short, dut.state, S_WAIT);
        end
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 20; i++) begin
            tick();
            frame_start = (i == 0);
            pic_active  = 1'b1;
        end
        tick();
        rst = 1'b1; pic_active = 1'b1;
        #2;
        n_vec++;
        if (err_range !== 1'b1 || err_overrun !== 1'b1 || wr_ready !== 1'b0 || pix_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_before: er=%b eo=%b rdy=%b pv=%b required 1 1 0 1", err_range, err_overrun, wr_ready, pix_valid);
        end
        tick();
        rst = 1'b0; pic_active = 1'b0;
        #2;
        n_vec++;
        if (pix_valid !== 1'b0 || pix_data !== '0 || dut.state !== S_WAIT || mem_we !== 1'b0 || mem_addr !== '0) begin
            n_bad++;
            $display("FAIL midrst_after: pv=%b pd=%h state=%0d we=%b addr=%h required 0 0 %0d 0 0",
                     pix_valid, pix_data, dut.state, mem_we, mem_addr, S_WAIT);
        end
        n_vec++;
        if (err_range !== 1'b0 || err_overrun !== 1'b0 || err_short !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_errs: er=%b eo=%b es=%b required 0 0 0", err_range, err_overrun, err_short);
        end
        prev_rd = 1'b0;
    endtask

    task automatic test_vblank_only();
        int k = 0;
        tick();
        rst_b = 1'b0;
        for (int v = 0; v < int'(PVB); v++) begin
            for (int h = 0; h < int'(PHB + ((v == int'(PVB) - 1) ? 0 : GAPB)); h++) begin
                tick();
                frame_start_b = (v == 0 && h == 0);
                pic_active_b  = (h < int'(PHB));
                wr_valid_b    = 1'b1;
                wr_addr_b     = AWB'(k);
                wr_data_b     = 24'hB0_0000 + DW'(k);
                #2;
                n_vec++;
                if (wr_ready_b !== 1'b0 || mem_we_b !== 1'b0) begin
                    n_bad++;
                    $display("FAIL vbo_frame: v=%0d h=%0d rdy=%b we=%b required 0 0", v, h, wr_ready_b, mem_we_b);
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            frame_start_b = 1'b0;
            pic_active_b  = 1'b0;
            wr_valid_b    = (i < 10);
            wr_addr_b     = AWB'(k);
            wr_data_b     = 24'hB0_0000 + DW'(k);
            #2;
            n_vec++;
            if (dut_b.state !== S_VBLANK || wr_ready_b !== 1'b1 || mem_we_b !== wr_valid_b) begin
                n_bad++;
                $display("FAIL vbo_blank: i=%0d state=%0d rdy=%b we=%b required %0d 1 %b",
                         i, dut_b.state, wr_ready_b, mem_we_b, S_VBLANK, wr_valid_b);
            end
            if (wr_valid_b) begin
                n_vec++;
                if (mem_addr_b !== AWB'(k) || mem_wdata_b !== 24'hB0_0000 + DW'(k)) begin
                    n_bad++;
                    $display("FAIL vbo_wr: addr=%h data=%h required %h %h", mem_addr_b, mem_wdata_b,
                             AWB'(k), 24'hB0_0000 + DW'(k));
                end
                k++;
            end
        end
        n_vec++;
        if (k != 10 || pix_valid_b !== 1'b0 || pix_data_b !== '0 || err_overrun_b !== 1'b0 || err_short_b !== 1'b0 || err_range_b !== 1'b0) begin
            n_bad++;
            $display("FAIL vbo_end: writes=%0d pv=%b pd=%h eo=%b es=%b er=%b required 10 0 0 0 0 0",
                     k, pix_valid_b, pix_data_b, err_overrun_b, err_short_b, err_range_b);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        prev_rd  = 1'b0;
        prev_idx = 0;
        test_reset();
        test_full_frame();
        test_hgap_writes();
        test_short_frame();
        test_range_overrun();
        test_reset_midline();
        test_vblank_only();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single-port frame-buffer RAM that replaces the picture ROM, and shares it between two requesters on the pixel clock.
- The display fetch path has absolute priority while the picture window is active.
- A host writer (valid/ready) is granted the port only when the display does not need it.
- Sits between the VGA timing generator (frame_start, pic_active) and the RAM; it sequences the display read pointer through the frame.

Parameters:
PIC_H, 280, picture width in pixels
PIC_V, 210, picture height in lines
ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W >= PIC_H*PIC_V
DATA_W, 24, pixel width ({R,G,B} 8:8:8)
WR_VBLANK_ONLY, 0, 1 = host writes granted only in S_VBLANK/S_WAIT; 0 = also in horizontal gaps

Ports:
clk25  in  1  pixel clock; only clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at horizontal count 0, vertical count 0
pic_active  in  1  high while the timing counters are inside the PIC_H x PIC_V window
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle (combinational)
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
mem_addr  out  ADDR_W  RAM address (combinational mux)
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after mem_addr
pix_data  out  DATA_W  pixel to DAC; 0 when pix_valid=0
pix_valid  out  1  pic_active delayed 1 cycle, qualified by state
err_overrun  out  1  sticky: pic_active seen outside S_FRAME
err_short  out  1  sticky: frame_start arrived before all PIC_H*PIC_V reads were issued
err_range  out  1  sticky: write accepted with wr_addr >= PIC_H*PIC_V (write suppressed)

Behaviour:
- Reset: state=S_WAIT, rd_ptr=0, pix_cnt=0, pix_valid=0, pix_data=0, all err_*=0, mem_we=0.
- FSM states: S_WAIT, S_FRAME, S_VBLANK.
  - S_WAIT -> S_FRAME on frame_start.
  - S_FRAME -> S_VBLANK in the cycle after the read with pix_cnt = PIC_H*PIC_V-1 is issued.
  - S_VBLANK -> S_FRAME on frame_start.
  - frame_start in S_FRAME: set err_short, restart the frame (rd_ptr=0, pix_cnt=0), stay in S_FRAME.
- frame_start restarts the frame in any state. If pic_active is high in the same cycle, address 0 is issued that cycle and rd_ptr becomes 1.
- Display read (S_FRAME, or the frame_start cycle, with pic_active=1):
  - mem_addr=rd_ptr, mem_we=0.
  - rd_ptr increments each read; wraps to 0 after PIC_H*PIC_V-1.
  - pix_cnt counts issued reads.
- Read latency: pix_valid(t+1) = read issued at t; pix_data(t+1) = mem_rdata. pix_data=0 whenever pix_valid=0. Display reads are never stalled.
- pic_active=1 in S_WAIT or S_VBLANK (without frame_start): no read issued, err_overrun set, pix_valid=0.
- wr_ready = !rst && !pic_active && (state != S_FRAME || WR_VBLANK_ONLY==0).
- Write transfer = wr_valid && wr_ready:
  - mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1 if wr_addr < PIC_H*PIC_V.
  - Otherwise mem_we=0 and err_range is set; the transfer still completes.
- One write per cycle; back-to-back writes are allowed. No write is ever issued in a cycle that has a display read.
- Idle cycle: mem_addr=rd_ptr, mem_we=0, mem_wdata=0.
- Errors clear only on rst.
- rst mid-frame: next cycle behaves exactly as after power-on reset. The in-flight read is discarded (pix_valid=0).
- pix_cnt width is ADDR_W+1; PIC_H*PIC_V is computed as a localparam at full width.

Decomposition:
- Shared package vga_pkg: HA/HF/HS/HB/HT, VA/VF/VS/VB/VT, PIC_H/PIC_V defaults, PIX_TOTAL localparam, state enum {S_WAIT,S_FRAME,S_VBLANK}.
- One sub-module, vga_fb_rd_ptr: read pointer and pix_cnt with load-zero, increment and wrap. It outputs rd_ptr and a last_pix flag.

Test Plan:
- Reset, frame_start, pic_active for 280x210 window cycles with RAM preloaded data=addr -> pix_data sequence 0..58799 one cycle after each read; state becomes S_VBLANK after read 58799; no errors.
- wr_valid held high across a line -> wr_ready=0 and mem_we=0 exactly while pic_active=1; writes land in horizontal gaps; readback of written addr matches.
- WR_VBLANK_ONLY=1, same stimulus -> wr_ready=0 throughout S_FRAME; 10 queued writes complete in the first 10 S_VBLANK cycles.
- frame_start after only 1000 reads -> err_short=1, next read address 0, pix_cnt restarted.
- Write to addr 58800 -> wr_ready=1, mem_we=0, err_range=1; pic_active without frame_start after reset -> err_overrun=1, pix_valid=0.
- rst asserted mid-line -> next cycle pix_valid=0, state S_WAIT, errors cleared, mem_we=0.
